// File: rtl/cb_config_loader.sv
`default_nettype none
// ============================================================================
// Module   : cb_config_loader
// Brief    : Bit-serial loader that assembles, validates and writes 35-bit
//            connection-block configuration words with a one-hot strobe.
// Revision : 1.0
// ============================================================================
module cb_config_loader #(
  parameter  int NUM_CB = 4,
  parameter  int CFG_W  = 35,
  localparam int IDX_W  = (NUM_CB > 1) ? $clog2(NUM_CB) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic              cfg_bit,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic [CFG_W-1:0]  cbconfig,
  output logic [NUM_CB-1:0] cb_sel,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [IDX_W-1:0]  error_cb
);

  localparam int CNT_W = $clog2(CFG_W);

  localparam logic [2:0] c_idle  = 3'd0;
  localparam logic [2:0] c_shift = 3'd1;
  localparam logic [2:0] c_check = 3'd2;
  localparam logic [2:0] c_write = 3'd3;
  localparam logic [2:0] c_done  = 3'd4;
  localparam logic [2:0] c_error = 3'd5;

  localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(CFG_W - 1);
  localparam logic [IDX_W-1:0] c_last_cb  = IDX_W'(NUM_CB - 1);

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [CFG_W-1:0] r_sr;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [IDX_W-1:0] r_cb_idx;
  logic [CFG_W-1:0] r_cbconfig;
  logic             r_error;
  logic [IDX_W-1:0] r_error_cb;
  logic             w_accept;
  logic             w_restart;
  logic [4:0]       w_field_ok;
  logic             w_legal;

  assign w_accept  = cfg_valid && (r_state == c_shift);
  assign w_restart = cfg_start && ((r_state == c_idle) || (r_state == c_error));

  // Fields 0-3 are inputs (either or both ends may drive); field 4 is the
  // output field where driving both ends would put two drivers on one track.
  for (genvar k = 0; k < 5; k++) begin : g_field
    logic [6:0] w_f;
    logic [4:0] w_m;
    logic       w_onehot;
    assign w_f      = r_sr[7*k +: 7];
    assign w_m      = w_f[5:1];
    assign w_onehot = (w_m != 5'd0) && ((w_m & (w_m - 5'd1)) == 5'd0);
    if (k == 4) begin : g_out
      assign w_field_ok[k] = (w_f == 7'd0) || (w_onehot && (w_f[6] ^ w_f[0]));
    end else begin : g_in
      assign w_field_ok[k] = (w_f == 7'd0) || (w_onehot && (w_f[6] | w_f[0]));
    end
  end

  assign w_legal = &w_field_ok;

  always_ff @(posedge clk) begin
    if (reset) r_state <= c_idle;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_idle:  if (cfg_start) w_next = c_shift;
      c_shift: if (w_accept && (r_bit_cnt == c_last_bit)) w_next = c_check;
      c_check: w_next = w_legal ? c_write : c_error;
      c_write: w_next = (r_cb_idx == c_last_cb) ? c_done : c_shift;
      c_done:  w_next = c_idle;
      c_error: if (cfg_start) w_next = c_shift;
      default: w_next = c_idle;
    endcase
  end

  always_comb begin
    cfg_ready = (r_state == c_shift);
    busy      = (r_state == c_shift) || (r_state == c_check) || (r_state == c_write);
    done      = (r_state == c_done);
    cb_sel    = '0;
    if (r_state == c_write) cb_sel = NUM_CB'(1) << r_cb_idx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr       <= '0;
      r_bit_cnt  <= '0;
      r_cb_idx   <= '0;
      r_cbconfig <= '0;
      r_error    <= 1'b0;
      r_error_cb <= '0;
    end else begin
      if (w_restart) begin
        r_bit_cnt  <= '0;
        r_cb_idx   <= '0;
        r_error    <= 1'b0;
        r_error_cb <= '0;
      end
      // Counter wraps on the last bit so the next word starts from zero.
      if (w_accept) begin
        r_sr      <= {r_sr[CFG_W-2:0], cfg_bit};
        r_bit_cnt <= (r_bit_cnt == c_last_bit) ? '0 : r_bit_cnt + CNT_W'(1);
      end
      // The word is latched a cycle early so cbconfig is stable throughout WRITE.
      if (r_state == c_check) begin
        if (w_legal) begin
          r_cbconfig <= r_sr;
        end else begin
          r_error    <= 1'b1;
          r_error_cb <= r_cb_idx;
        end
      end
      if ((r_state == c_write) && (r_cb_idx != c_last_cb)) r_cb_idx <= r_cb_idx + IDX_W'(1);
    end
  end

  assign cbconfig = r_cbconfig;
  assign error    = r_error;
  assign error_cb = r_error_cb;

endmodule
`default_nettype wire

// File: tb/tb_cb_config_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_cb_config_loader
// Brief    : Randomized self-checking bench for cb_config_loader.
// Revision : 1.0
// ============================================================================
module tb_cb_config_loader;
  localparam int NUM_CB = 4;
  localparam int CFG_W  = 35;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cfg_start = 1'b0;
  logic cfg_bit = 1'b0;
  logic cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [CFG_W-1:0]  cbconfig;
  logic [NUM_CB-1:0] cb_sel;
  logic              busy, done, error;
  logic [1:0]        error_cb;

  cb_config_loader #(.NUM_CB(NUM_CB), .CFG_W(CFG_W)) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_bit(cfg_bit),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cbconfig(cbconfig),
    .cb_sel(cb_sel), .busy(busy), .done(done), .error(error), .error_cb(error_cb)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [CFG_W-1:0]  wq[$];
  logic [NUM_CB-1:0] sq[$];
  int                tq[$];
  int                done_t[$];
  logic [CFG_W-1:0]  fw[NUM_CB];

  // Observed writes and done pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (cb_sel != '0) begin
      wq.push_back(cbconfig);
      sq.push_back(cb_sel);
      tq.push_back(cyc);
    end
    if (done) done_t.push_back(cyc);
  end

  function automatic bit legal(input logic [CFG_W-1:0] w);
    logic [6:0] f;
    for (int k = 0; k < 5; k++) begin
      f = w[7*k +: 7];
      if (f != 7'd0) begin
        if ($countones(f[5:1]) != 1) return 1'b0;
        if (f[6] == 1'b0 && f[0] == 1'b0) return 1'b0;
        if (k == 4 && f[6] && f[0]) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  function automatic logic [CFG_W-1:0] rand_word();
    logic [CFG_W-1:0] w;
    logic [4:0] m;
    logic [1:0] e;
    w = '0;
    for (int k = 0; k < 5; k++) begin
      e = 2'($urandom_range(0, 3));
      m = 5'b1 << $urandom_range(0, 4);
      if (k == 4 && e == 2'd3) e = 2'($urandom_range(1, 2));
      if (e != 2'd0) w[7*k +: 7] = {e[1], m, e[0]};
    end
    return w;
  endfunction

  // Model: blocks written are the prefix of words before the first illegal one.
  function automatic int n_good();
    for (int i = 0; i < NUM_CB; i++) if (!legal(fw[i])) return i;
    return NUM_CB;
  endfunction

  task automatic run_frame(input int pct, output int t0);
    int b;
    int guard;
    bit stop;
    stop = 1'b0;
    wq.delete(); sq.delete(); tq.delete(); done_t.delete();
    @(negedge clk); cfg_start = 1'b1; t0 = cyc;
    @(negedge clk); cfg_start = 1'b0;
    for (int i = 0; i < NUM_CB && !stop; i++) begin
      b = CFG_W - 1;
      guard = 0;
      while (b >= 0 && guard < 600) begin
        cfg_valid = ($urandom_range(0, 99) < pct);
        cfg_bit   = fw[i][b];
        if (cfg_valid && cfg_ready) b--;
        guard++;
        @(negedge clk);
      end
      total++;
      if (b >= 0) begin
        bad++;
        $display("FAIL bit_timeout word=%0d bits_left=%0d required=0", i, b + 1);
        stop = 1'b1;
      end
      if (!legal(fw[i])) stop = 1'b1;
    end
    cfg_valid = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; cfg_valid = 1'b1; cfg_start = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({cbconfig, cb_sel, cfg_ready, busy, done, error, error_cb} !== '0) begin
      bad++;
      $display("FAIL reset_outputs cbconfig=%h cb_sel=%b ready=%b busy=%b done=%b error=%b error_cb=%0d required=all0",
               cbconfig, cb_sel, cfg_ready, busy, done, error, error_cb);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (cfg_ready !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_no_ready ready=%b busy=%b required=0 0", cfg_ready, busy);
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_legal_frame();
    int t0;
    for (int i = 0; i < NUM_CB; i++) fw[i] = 35'h2_1000_0060;
    run_frame(100, t0);
    total++;
    if (sq.size() != NUM_CB) begin
      bad++; $display("FAIL legal_count got=%0d required=%0d", sq.size(), NUM_CB);
    end else begin
      for (int i = 0; i < NUM_CB; i++) begin
        total++;
        if (sq[i] !== NUM_CB'(1 << i) || wq[i] !== 35'h2_1000_0060 || tq[i] != t0 + 37 * (i + 1)) begin
          bad++;
          $display("FAIL legal_write%0d sel=%b cfg=%h cyc=%0d required sel=%b cfg=%h cyc=%0d",
                   i, sq[i], wq[i], tq[i] - t0, NUM_CB'(1 << i), 35'h2_1000_0060, 37 * (i + 1));
        end
      end
    end
    total++;
    if (done_t.size() != 1 || done_t[0] != t0 + NUM_CB * 37 + 1 || error !== 1'b0) begin
      bad++;
      $display("FAIL legal_done pulses=%0d at=%0d error=%b required 1 at %0d error 0",
               done_t.size(), (done_t.size() > 0) ? done_t[0] - t0 : -1, error, NUM_CB * 37 + 1);
    end
  endtask

  task automatic test_output_contention();
    int t0;
    fw[0] = 35'h2_1000_0060; fw[1] = 35'h2_1000_0060;
    fw[2] = 35'h6_1000_0000; fw[3] = 35'h2_1000_0060;
    run_frame(100, t0);
    repeat (20) @(negedge clk);
    total++;
    if (sq.size() != 2 || sq[0] !== 4'b0001 || sq[1] !== 4'b0010) begin
      bad++; $display("FAIL contention_writes count=%0d required=2 (0001,0010)", sq.size());
    end
    total++;
    if (error !== 1'b1 || error_cb !== 2'd2 || busy !== 1'b0 || done_t.size() != 0) begin
      bad++;
      $display("FAIL contention_error error=%b error_cb=%0d busy=%b dones=%0d required 1 2 0 0",
               error, error_cb, busy, done_t.size());
    end
  endtask

  task automatic test_restart_after_error();
    int t0;
    for (int i = 0; i < NUM_CB; i++) fw[i] = rand_word();
    run_frame(100, t0);
    total++;
    if (sq.size() != NUM_CB || sq[0] !== 4'b0001 || wq[0] !== fw[0] || error !== 1'b0 || done_t.size() != 1) begin
      bad++;
      $display("FAIL restart writes=%0d first_sel=%b error=%b dones=%0d required %0d 0001 0 1",
               sq.size(), (sq.size() > 0) ? sq[0] : 4'b0, error, done_t.size(), NUM_CB);
    end
  endtask

  task automatic test_bad_track();
    int t0;
    fw[0] = 35'h0000_2C00;
    for (int i = 1; i < NUM_CB; i++) fw[i] = 35'h2_1000_0060;
    run_frame(100, t0);
    total++;
    if (sq.size() != 0 || error !== 1'b1 || error_cb !== 2'd0) begin
      bad++;
      $display("FAIL bad_track writes=%0d error=%b error_cb=%0d required 0 1 0", sq.size(), error, error_cb);
    end
  endtask

  task automatic test_random_frames();
    int t0;
    int ng;
    int pct;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NUM_CB; i++) begin
        fw[i] = rand_word();
        if ($urandom_range(0, 9) == 0) fw[i][$urandom_range(0, CFG_W - 1)] ^= 1'b1;
      end
      pct = (r < 2) ? 50 : $urandom_range(30, 100);
      ng = n_good();
      run_frame(pct, t0);
      total++;
      if (sq.size() != ng) begin
        bad++; $display("FAIL rand%0d_count got=%0d required=%0d", r, sq.size(), ng);
      end else begin
        for (int i = 0; i < ng; i++) begin
          total++;
          if (sq[i] !== NUM_CB'(1 << i) || wq[i] !== fw[i]) begin
            bad++;
            $display("FAIL rand%0d_write%0d sel=%b cfg=%h required sel=%b cfg=%h",
                     r, i, sq[i], wq[i], NUM_CB'(1 << i), fw[i]);
          end
        end
      end
      total++;
      if (error !== (ng != NUM_CB) || (ng != NUM_CB && error_cb !== 2'(ng)) ||
          done_t.size() != ((ng == NUM_CB) ? 1 : 0)) begin
        bad++;
        $display("FAIL rand%0d_status error=%b error_cb=%0d dones=%0d required error=%b cb=%0d",
                 r, error, error_cb, done_t.size(), ng != NUM_CB, ng);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int t0;
    for (int i = 0; i < NUM_CB; i++) fw[i] = rand_word();
    wq.delete(); sq.delete(); tq.delete(); done_t.delete();
    @(negedge clk); cfg_start = 1'b1;
    @(negedge clk); cfg_start = 1'b0;
    for (int n = 0; n < 20; n++) begin
      cfg_valid = 1'b1; cfg_bit = fw[0][CFG_W - 1 - n];
      @(negedge clk);
    end
    reset = 1'b1; cfg_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    total++;
    if (sq.size() != 0 || busy !== 1'b0 || cfg_ready !== 1'b0 || done_t.size() != 0) begin
      bad++;
      $display("FAIL midframe_abort writes=%0d busy=%b ready=%b dones=%0d required 0 0 0 0",
               sq.size(), busy, cfg_ready, done_t.size());
    end
    run_frame(100, t0);
    total++;
    if (sq.size() != NUM_CB) begin
      bad++; $display("FAIL midframe_reload count=%0d required=%0d", sq.size(), NUM_CB);
    end else begin
      for (int i = 0; i < NUM_CB; i++) begin
        total++;
        if (wq[i] !== fw[i] || sq[i] !== NUM_CB'(1 << i)) begin
          bad++;
          $display("FAIL midframe_word%0d cfg=%h sel=%b required cfg=%h sel=%b",
                   i, wq[i], sq[i], fw[i], NUM_CB'(1 << i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_legal_frame();
    test_output_contention();
    test_restart_after_error();
    test_bad_track();
    test_random_frames();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
